m_enemy_hit_detect: RTL

Collision responder for one M-class enemy plane. On every game update tick it scans the player-bullet table once and compares each live bullet against the plane's hit box. It drives the plane's level `Hit` input for the following tick and issues clear pulses for the bullets that struck. It sits between the player-bullet store and `m_enemyPlane_logic`. It consumes `PosX_out`/`PosY_out`/`isLive` and produces `Hit`.

---
 rtl/game_pkg.sv | 19 +
 rtl/box_overlap.sv | 34 +++
 rtl/m_enemy_hit_detect.sv | 136 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game constants: hit-box sizes, the screen coordinate type,
// the tick edge-sync depth and the hit-detector scan states.
package game_pkg;

  localparam int M_PLANE_W       = 24;
  localparam int M_PLANE_H       = 24;
  localparam int PLAYER_BULLET_W = 4;
  localparam int PLAYER_BULLET_H = 8;
  localparam int EDGE_SYNC_DEPTH = 2;

  typedef logic [7:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } hit_state_t;

endpackage

// File: rtl/box_overlap.sv
// Combinational 2-D box intersection on 9-bit unsigned coordinates, so boxes
// near the right/bottom screen edge never wrap. Touching edges do not count.
module box_overlap
  import game_pkg::*;
#(
  parameter int A_W = M_PLANE_W,
  parameter int A_H = M_PLANE_H,
  parameter int B_W = PLAYER_BULLET_W,
  parameter int B_H = PLAYER_BULLET_H
) (
  input  coord_t i_ax,
  input  coord_t i_ay,
  input  coord_t i_bx,
  input  coord_t i_by,
  output logic   o_overlap
);

  logic [8:0] w_ax, w_ay, w_bx, w_by;
  logic [8:0] w_ax_end, w_ay_end, w_bx_end, w_by_end;

  assign w_ax = {1'b0, i_ax};
  assign w_ay = {1'b0, i_ay};
  assign w_bx = {1'b0, i_bx};
  assign w_by = {1'b0, i_by};

  assign w_ax_end = w_ax + 9'(A_W);
  assign w_ay_end = w_ay + 9'(A_H);
  assign w_bx_end = w_bx + 9'(B_W);
  assign w_by_end = w_by + 9'(B_H);

  assign o_overlap = (w_bx_end > w_ax) && (w_bx < w_ax_end) &&
                     (w_by_end > w_ay) && (w_by < w_ay_end);

endmodule

// File: rtl/m_enemy_hit_detect.sv
// Per-tick bullet-table scan for one M-class enemy plane: clears every live
// bullet inside the plane box and publishes a level Hit for the next tick.
module m_enemy_hit_detect
  import game_pkg::*;
#(
  parameter int  BULLET_NUM = 8,
  parameter int  PLANE_W    = M_PLANE_W,
  parameter int  PLANE_H    = M_PLANE_H,
  parameter int  BULLET_W   = PLAYER_BULLET_W,
  parameter int  BULLET_H   = PLAYER_BULLET_H,
  localparam int IDX_W      = $clog2(BULLET_NUM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             update_clk,
  input  logic             plane_live,
  input  coord_t           plane_x,
  input  coord_t           plane_y,
  output logic [IDX_W-1:0] bullet_rd_idx,
  input  logic             bullet_valid,
  input  coord_t           bullet_x,
  input  coord_t           bullet_y,
  output logic             bullet_clr,
  output logic [IDX_W-1:0] bullet_clr_idx,
  output logic             Hit,
  output logic [3:0]       hit_num,
  output logic             busy
);

  logic [EDGE_SYNC_DEPTH-1:0] r_sync;
  logic                       r_sync_last;
  logic                       r_tick;
  hit_state_t                 r_state, w_state_next;
  coord_t                     r_px, r_py;
  logic [IDX_W-1:0]           r_rd_idx, r_cmp_idx;
  logic                       r_cmp_vld;
  logic [3:0]                 r_count, w_count_next;
  logic                       r_hit;
  logic [3:0]                 r_hit_num;
  logic                       w_overlap, w_match, w_last_idx;

  // Tick edge detect: sync chain, then a registered rising-edge pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync      <= '0;
      r_sync_last <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_sync      <= {r_sync[EDGE_SYNC_DEPTH-2:0], update_clk};
      r_sync_last <= r_sync[EDGE_SYNC_DEPTH-1];
      r_tick      <= r_sync[EDGE_SYNC_DEPTH-1] & ~r_sync_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  assign w_last_idx = (r_rd_idx == IDX_W'(BULLET_NUM - 1));

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (r_tick && plane_live) w_state_next = ST_SCAN;
      ST_SCAN: if (w_last_idx) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  box_overlap #(
    .A_W(PLANE_W),
    .A_H(PLANE_H),
    .B_W(BULLET_W),
    .B_H(BULLET_H)
  ) u_overlap (
    .i_ax      (r_px),
    .i_ay      (r_py),
    .i_bx      (bullet_x),
    .i_by      (bullet_y),
    .o_overlap (w_overlap)
  );

  // Compare stage trails the read address by one cycle, matching RAM latency;
  // the DONE cycle still carries the compare of the last slot.
  assign w_match      = r_cmp_vld & bullet_valid & w_overlap;
  assign w_count_next = (w_match && (r_count != 4'hF)) ? r_count + 4'd1 : r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_px      <= '0;
      r_py      <= '0;
      r_rd_idx  <= '0;
      r_cmp_idx <= '0;
      r_cmp_vld <= 1'b0;
      r_count   <= '0;
      r_hit     <= 1'b0;
      r_hit_num <= '0;
    end else begin
      r_cmp_vld <= (r_state == ST_SCAN);
      r_cmp_idx <= r_rd_idx;
      unique case (r_state)
        ST_IDLE: begin
          if (r_tick) begin
            r_px     <= plane_x;
            r_py     <= plane_y;
            r_rd_idx <= '0;
            if (!plane_live) begin
              r_hit     <= 1'b0;
              r_hit_num <= '0;
            end
          end
        end
        ST_SCAN: begin
          r_rd_idx <= w_last_idx ? '0 : r_rd_idx + 1'b1;
          r_count  <= w_count_next;
        end
        ST_DONE: begin
          r_hit     <= (w_count_next != 4'd0);
          r_hit_num <= w_count_next;
          r_count   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bullet_rd_idx  = r_rd_idx;
  assign bullet_clr     = w_match;
  assign bullet_clr_idx = r_cmp_idx;
  assign Hit            = r_hit;
  assign hit_num        = r_hit_num;
  assign busy           = (r_state != ST_IDLE);

endmodule
